// File: rtl/mv_result_uart_tx_pkg.sv
// Shared definitions for the matrix-vector result UART transmitter:
// default word width, FSM state encoding and the parity helper.
package mv_result_uart_tx_pkg;

  localparam int unsigned MV_DATA_W = 6;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  // Even parity: XOR of all bits, so the frame's total count of ones is even.
  function automatic logic even_parity(input logic [31:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/mv_sync_fifo.sv
// Synchronous FIFO buffering result words ahead of the serial transmitter.
// Read data is the head word and is valid whenever the FIFO is not empty.
module mv_sync_fifo #(
  parameter int DATA_W     = 6,
  parameter int FIFO_DEPTH = 4,
  localparam int PTR_W     = $clog2(FIFO_DEPTH),
  localparam int CNT_W     = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic              push_ok_s;
  logic              pop_ok_s;

  assign full      = (count_r == CNT_W'(FIFO_DEPTH));
  assign empty     = (count_r == {CNT_W{1'b0}});
  assign count     = count_r;
  assign rdata     = mem_r[rd_ptr_r];
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;

  // Storage array; no reset needed since count gates every read.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers and occupancy; pointers wrap naturally because depth is a power of 2.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/mv_result_uart_tx.sv
// Result-path UART transmitter: buffers words in a FIFO and sends each as
// start, DATA_W data bits LSB first, optional even parity, stop.
module mv_result_uart_tx
  import mv_result_uart_tx_pkg::*;
#(
  parameter int DATA_W       = MV_DATA_W,
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter int PARITY_EN    = 1,
  localparam int CNT_W       = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] res_data,
  input  logic              res_valid,
  output logic              res_ready,
  output logic              tx_serial,
  output logic              tx_busy,
  output logic [CNT_W-1:0]  fifo_count,
  output logic              overflow
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  tx_state_e         state_r;
  logic [BAUD_W-1:0] baud_r;
  logic [IDX_W-1:0]  bit_idx_r;
  logic [DATA_W-1:0] shift_r;
  logic              par_r;
  logic [DATA_W-1:0] head_s;
  logic              full_s;
  logic              empty_s;
  logic              push_s;
  logic              pop_s;
  logic              bit_end_s;

  assign res_ready = !full_s;
  assign push_s    = res_valid && res_ready;
  assign bit_end_s = (baud_r == BAUD_W'(CLKS_PER_BIT - 1));

  mv_sync_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (res_data),
    .rdata (head_s),
    .full  (full_s),
    .empty (empty_s),
    .count (fifo_count)
  );

  // Pop the head word when a new frame begins: from IDLE, or chained after a stop bit.
  always_comb begin
    pop_s = 1'b0;
    if ((state_r == ST_IDLE) || ((state_r == ST_STOP) && bit_end_s)) begin
      pop_s = !empty_s;
    end else begin
      pop_s = 1'b0;
    end
  end

  // Frame FSM with baud counter, bit index, shift register and registered line.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      baud_r    <= {BAUD_W{1'b0}};
      bit_idx_r <= {IDX_W{1'b0}};
      shift_r   <= {DATA_W{1'b0}};
      par_r     <= 1'b0;
      tx_serial <= 1'b1;
      tx_busy   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          baud_r <= {BAUD_W{1'b0}};
          if (pop_s) begin
            state_r   <= ST_START;
            shift_r   <= head_s;
            par_r     <= even_parity(32'(head_s));
            tx_serial <= 1'b0;
            tx_busy   <= 1'b1;
          end
        end
        ST_START: begin
          if (bit_end_s) begin
            state_r   <= ST_DATA;
            baud_r    <= {BAUD_W{1'b0}};
            bit_idx_r <= {IDX_W{1'b0}};
            tx_serial <= shift_r[0];
            shift_r   <= {1'b0, shift_r[DATA_W-1:1]};
          end else begin
            baud_r <= baud_r + BAUD_W'(1);
          end
        end
        ST_DATA: begin
          if (bit_end_s) begin
            baud_r <= {BAUD_W{1'b0}};
            if (bit_idx_r == IDX_W'(DATA_W - 1)) begin
              if (PARITY_EN != 0) begin
                state_r   <= ST_PARITY;
                tx_serial <= par_r;
              end else begin
                state_r   <= ST_STOP;
                tx_serial <= 1'b1;
              end
            end else begin
              bit_idx_r <= bit_idx_r + IDX_W'(1);
              tx_serial <= shift_r[0];
              shift_r   <= {1'b0, shift_r[DATA_W-1:1]};
            end
          end else begin
            baud_r <= baud_r + BAUD_W'(1);
          end
        end
        ST_PARITY: begin
          if (bit_end_s) begin
            state_r   <= ST_STOP;
            baud_r    <= {BAUD_W{1'b0}};
            tx_serial <= 1'b1;
          end else begin
            baud_r <= baud_r + BAUD_W'(1);
          end
        end
        ST_STOP: begin
          if (bit_end_s) begin
            baud_r <= {BAUD_W{1'b0}};
            if (pop_s) begin
              state_r   <= ST_START;
              shift_r   <= head_s;
              par_r     <= even_parity(32'(head_s));
              tx_serial <= 1'b0;
            end else begin
              state_r   <= ST_IDLE;
              tx_serial <= 1'b1;
              tx_busy   <= 1'b0;
            end
          end else begin
            baud_r <= baud_r + BAUD_W'(1);
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          baud_r    <= {BAUD_W{1'b0}};
          tx_serial <= 1'b1;
          tx_busy   <= 1'b0;
        end
      endcase
    end
  end

  // Sticky flag for words offered while the FIFO was full.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (res_valid && !res_ready) begin
      overflow <= 1'b1;
    end else begin
      overflow <= overflow;
    end
  end

endmodule
